// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run controller: FSM state codes,
// the PC width and the breakpoint compare helper.
package cpu_run_ctrl_pkg;

    // Width of the fetch PC and the breakpoint address.
    localparam int PC_W = 32;

    // Run-control FSM state codes; the numeric values are visible on the
    // state output, so they must stay fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } run_state_e;

    // True when breakpoints are enabled and the current PC equals the
    // breakpoint address.
    function automatic logic bp_match(
        input logic            en,
        input logic [PC_W-1:0] pc_v,
        input logic [PC_W-1:0] addr_v
    );
        return en && (pc_v == addr_v);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, debounce counter and
// rising-edge detector. The debounced level only changes after DEB_CYC
// consecutive synchronised samples that disagree with the current level;
// any sample agreeing with the level restarts the count.
module btn_debounce #(
    parameter int DEB_CYC = 1000000
) (
    input  logic CLK,
    input  logic rstn,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    // Counter only has to reach DEB_CYC-1; keep at least one bit.
    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_d;

    // Bring the asynchronous button into the CLK domain.
    always_ff @(posedge CLK) begin
        if (!rstn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive samples that differ from the accepted level and
    // accept the new value once the count is complete.
    always_ff @(posedge CLK) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync2 == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Delayed copy of the level for edge detection.
    always_ff @(posedge CLK) begin
        if (!rstn) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= r_level;
        end
    end

    assign level      = r_level;
    assign rise_pulse = r_level & ~r_level_d;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: turns a run switch, a single-step button and a
// PC breakpoint into a pipeline clock enable, and counts enabled cycles.
// The FSM state is exported on the state port for observation.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int CYC_W   = 32,
    parameter int DEB_CYC = 1000000
) (
    input  logic             CLK,
    input  logic             rstn,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic             cyc_clr,
    output logic             cpu_en,
    output logic [CYC_W-1:0] cycles,
    output logic [1:0]       state,
    output logic             bp_hit
);

    // Run switch path: synchroniser and edge detector, no debounce.
    logic       r_run_s1;
    logic       r_run_s2;
    logic       r_run_d;
    logic [1:0] r_run_vld;
    logic       r_run_armed;
    logic       w_run_rise;

    // Step button path.
    logic       w_step_level;
    logic       w_step_rise;
    logic       w_step_pulse;

    // FSM, counter and breakpoint status.
    run_state_e       r_state;
    run_state_e       w_next_state;
    logic [CYC_W-1:0] r_cycles;
    logic             r_bp_hit;
    logic             w_bp_match;
    logic             w_cpu_en;

    // Synchronise run_sw and remember the previous synchronised value.
    always_ff @(posedge CLK) begin
        if (!rstn) begin
            r_run_s1 <= 1'b0;
            r_run_s2 <= 1'b0;
            r_run_d  <= 1'b0;
        end else begin
            r_run_s1 <= run_sw;
            r_run_s2 <= r_run_s1;
            r_run_d  <= r_run_s2;
        end
    end

    // The synchroniser flops hold reset values, not real samples, for two
    // cycles after reset. A run edge is only honoured once a genuine low
    // has been sampled, so a switch held high through reset never starts
    // a run.
    always_ff @(posedge CLK) begin
        if (!rstn) begin
            r_run_vld   <= 2'b00;
            r_run_armed <= 1'b0;
        end else begin
            r_run_vld   <= {r_run_vld[0], 1'b1};
            r_run_armed <= r_run_armed | (r_run_vld[1] & ~r_run_s2);
        end
    end

    assign w_run_rise = r_run_s2 & ~r_run_d & r_run_armed;

    btn_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_step_deb (
        .CLK        (CLK),
        .rstn       (rstn),
        .raw        (step_btn),
        .level      (w_step_level),
        .rise_pulse (w_step_rise)
    );

    // The rise pulse already implies a high level; gating keeps the pulse
    // tied to the accepted level.
    assign w_step_pulse = w_step_rise & w_step_level;

    assign w_bp_match = bp_match(bp_en, pc, bp_addr);

    // Next-state logic. Run edges take priority over steps in IDLE; in
    // BREAK only a step or a dropped switch leaves the state, so changes
    // to the breakpoint inputs there have no effect.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_run_rise) begin
                    w_next_state = ST_RUN;
                end else if (w_step_pulse) begin
                    w_next_state = ST_STEP;
                end
            end
            ST_RUN: begin
                if (!r_run_s2) begin
                    w_next_state = ST_IDLE;
                end else if (w_bp_match) begin
                    w_next_state = ST_BREAK;
                end
            end
            ST_STEP: begin
                w_next_state = ST_IDLE;
            end
            ST_BREAK: begin
                if (w_step_pulse) begin
                    w_next_state = ST_STEP;
                end else if (!r_run_s2) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register with breakpoint flag registered alongside it.
    always_ff @(posedge CLK) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_bp_hit <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_bp_hit <= (w_next_state == ST_BREAK);
        end
    end

    // Enable is suppressed in the very cycle the PC reaches the breakpoint,
    // so the instruction at bp_addr is not fetched before the stop.
    assign w_cpu_en = ((r_state == ST_RUN) && !w_bp_match) || (r_state == ST_STEP);

    // Enabled-cycle counter; clear wins over increment, wraps naturally.
    always_ff @(posedge CLK) begin
        if (!rstn) begin
            r_cycles <= '0;
        end else if (cyc_clr) begin
            r_cycles <= '0;
        end else if (w_cpu_en) begin
            r_cycles <= r_cycles + CYC_W'(1);
        end
    end

    assign cpu_en = w_cpu_en;
    assign cycles = r_cycles;
    assign state  = r_state;
    assign bp_hit = r_bp_hit;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl with CYC_W=4 and DEB_CYC=4. Inputs change on the
// falling edge; outputs are sampled 1 ns before the next rising edge. The
// bench acts as the PCU: pc advances by 4 after every cycle with cpu_en=1.
module tb_cpu_run_ctrl;

    logic        CLK = 1'b0;
    logic        rstn = 1'b0;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        cyc_clr = 1'b0;
    logic        cpu_en;
    logic [3:0]  cycles;
    logic [1:0]  state;
    logic        bp_hit;

    int   total = 0;
    int   bad = 0;
    logic last_en = 1'b0;

    typedef struct packed {
        logic        rstn;
        logic        run;
        logic        step;
        logic        bp_en;
        logic [31:0] bp_addr;
        logic        chk;
        logic [1:0]  st;
        logic        en;
        logic [3:0]  cyc;
        logic        hit;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];

    // Clock
    always #5 CLK = ~CLK;

    cpu_run_ctrl #(
        .CYC_W   (4),
        .DEB_CYC (4)
    ) dut (
        .CLK      (CLK),
        .rstn     (rstn),
        .run_sw   (run_sw),
        .step_btn (step_btn),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .pc       (pc),
        .cyc_clr  (cyc_clr),
        .cpu_en   (cpu_en),
        .cycles   (cycles),
        .state    (state),
        .bp_hit   (bp_hit)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; returns at the sample point.
    task automatic drive(input logic rstn_v, input logic run_v, input logic step_v,
                         input logic bp_en_v, input logic [31:0] addr_v, input logic clr_v);
        @(negedge CLK);
        if (!rstn_v) pc = 32'h0;
        else if (last_en) pc = pc + 32'd4;
        rstn     = rstn_v;
        run_sw   = run_v;
        step_btn = step_v;
        bp_en    = bp_en_v;
        bp_addr  = addr_v;
        cyc_clr  = clr_v;
        #4;
        last_en = rstn_v ? cpu_en : 1'b0;
    endtask

    task automatic add_rows(input int n, input logic rstn_v, input logic run_v, input logic step_v,
                            input logic bp_en_v, input logic [31:0] addr_v, input logic chk_v,
                            input logic [1:0] st_v, input logic en_v, input logic [3:0] cyc_v,
                            input logic hit_v);
        vec_t v;
        v.rstn = rstn_v; v.run = run_v; v.step = step_v; v.bp_en = bp_en_v;
        v.bp_addr = addr_v; v.chk = chk_v; v.st = st_v; v.en = en_v; v.cyc = cyc_v; v.hit = hit_v;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        vec_t       v;
        logic [7:0] e;
        int         en_cnt;
        logic       s_b;

        // Cycle table: reset with run held, run to breakpoint at 0xC,
        // step past it, rerun from 0x10, then drop the run switch.
        //       n  rstn run stp bpe addr      chk st en cyc hit
        add_rows(1, 0,   1,  0,  1,  32'h0C,   0,  0, 0, 0,  0);
        add_rows(1, 0,   1,  0,  1,  32'h0C,   1,  0, 0, 0,  0);
        add_rows(5, 1,   1,  0,  1,  32'h0C,   1,  0, 0, 0,  0);
        add_rows(3, 1,   0,  0,  1,  32'h0C,   1,  0, 0, 0,  0);
        add_rows(3, 1,   1,  0,  1,  32'h0C,   1,  0, 0, 0,  0);
        add_rows(1, 1,   1,  0,  1,  32'h0C,   1,  1, 1, 0,  0);
        add_rows(1, 1,   1,  0,  1,  32'h0C,   1,  1, 1, 1,  0);
        add_rows(1, 1,   1,  0,  1,  32'h0C,   1,  1, 1, 2,  0);
        add_rows(1, 1,   1,  0,  1,  32'h0C,   1,  1, 0, 3,  0);
        add_rows(1, 1,   1,  0,  1,  32'h0C,   1,  3, 0, 3,  1);
        add_rows(2, 1,   1,  0,  0,  32'h20,   1,  3, 0, 3,  1);
        add_rows(7, 1,   1,  1,  1,  32'h0C,   1,  3, 0, 3,  1);
        add_rows(1, 1,   1,  1,  1,  32'h0C,   1,  2, 1, 3,  0);
        add_rows(3, 1,   0,  0,  1,  32'h0C,   1,  0, 0, 4,  0);
        add_rows(3, 1,   1,  0,  1,  32'h0C,   1,  0, 0, 4,  0);
        add_rows(1, 1,   1,  0,  1,  32'h0C,   1,  1, 1, 4,  0);
        add_rows(1, 1,   1,  0,  1,  32'h0C,   1,  1, 1, 5,  0);
        add_rows(1, 1,   0,  0,  1,  32'h0C,   1,  1, 1, 6,  0);
        add_rows(1, 1,   0,  0,  1,  32'h0C,   1,  1, 1, 7,  0);
        add_rows(1, 1,   0,  0,  1,  32'h0C,   1,  1, 1, 8,  0);
        add_rows(2, 1,   0,  0,  1,  32'h0C,   1,  0, 0, 9,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.chk) exp_q.push_back({v.st, v.en, v.hit, v.cyc});
            drive(v.rstn, v.run, v.step, v.bp_en, v.bp_addr, 1'b0);
            if (v.chk) begin
                e = exp_q.pop_front();
                check($sformatf("row%0d_state", i), 32'(state), 32'(e[7:6]));
                check($sformatf("row%0d_cpu_en", i), 32'(cpu_en), 32'(e[5]));
                check($sformatf("row%0d_bp_hit", i), 32'(bp_hit), 32'(e[4]));
                check($sformatf("row%0d_cycles", i), 32'(cycles), 32'(e[3:0]));
            end
        end

        // Bouncing step from IDLE: 1-0-1 then held, then released.
        en_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            s_b = (i == 1) ? 1'b0 : (i <= 8);
            drive(1'b1, 1'b0, s_b, 1'b0, 32'h0C, 1'b0);
            if (cpu_en) en_cnt++;
        end
        check("bounce_en_count", 32'(en_cnt), 32'd1);
        check("bounce_cycles", 32'(cycles), 32'd10);
        check("bounce_state", 32'(state), 32'd0);
        check("bounce_bp_hit", 32'(bp_hit), 32'd0);

        // Run edge and step pulse land in the same IDLE cycle.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0C, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, (i >= 4), 1'b1, 1'b0, 32'h0C, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0C, 1'b0);
        check("simul_pre_state", 32'(state), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b0);
        check("simul_state", 32'(state), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b0);
        check("simul_state_hold", 32'(state), 32'd1);
        check("simul_cpu_en", 32'(cpu_en), 32'd1);

        // Reset in the middle of a run, switch kept high afterwards.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b0);
        check("midrun_rst_state", 32'(state), 32'd0);
        check("midrun_rst_cpu_en", 32'(cpu_en), 32'd0);
        check("midrun_rst_cycles", 32'(cycles), 32'd0);
        check("midrun_rst_bp_hit", 32'(bp_hit), 32'd0);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b0);
        check("held_run_state", 32'(state), 32'd0);
        check("held_run_cpu_en", 32'(cpu_en), 32'd0);

        // Counter wrap after 16 enabled cycles, then clear while running.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0C, 1'b0);
        en_cnt = 0;
        for (int i = 0; i < 40 && en_cnt < 17; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b0);
            if (cpu_en) begin
                en_cnt++;
                if (en_cnt == 17) check("wrap_to_zero", 32'(cycles), 32'd0);
            end
        end
        check("wrap_reached", 32'(en_cnt), 32'd17);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b0);
        check("wrap_cycles_1", 32'(cycles), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b1);
        check("clr_cpu_en", 32'(cpu_en), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b0);
        check("clr_cycles_0", 32'(cycles), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b0);
        check("clr_cycles_1", 32'(cycles), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
